sweep_ctrl: RTL
===============

Name: sweep_ctrl

Overview:
Sequencer that drives a bounded up/down counter through programmable triangle sweeps, lo→hi→lo, repeated N times, with an optional dwell at each turnaround. It sits between a host that issues start/abort with a sweep configuration and the counter datapath, and reports busy/done/err status. The counter is an internal sub-module instance. Its value and direction are exported to downstream logic.

Parameters:
WIDTH, 4, counter and bound width
SWEEP_W, 4, width of sweep-count input
DWELL_W, 4, width of dwell-length input

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  request a run, sampled only in IDLE
abort  in  1  terminate an active run
lo  in  WIDTH  lower bound, latched on accepted start
hi  in  WIDTH  upper bound, latched on accepted start
n_sweeps  in  SWEEP_W  number of full lo→hi→lo sweeps, latched
dwell  in  DWELL_W  extra hold cycles at each turnaround, latched
count  out  WIDTH  current counter value, registered
dir  out  1  1 = up/next move up, 0 = down, registered
busy  out  1  high in UP, DWELL_HI, DOWN, DWELL_LO
done  out  1  one-cycle pulse (DONE state) on normal completion
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (rst=0 at edge): state IDLE, count=0, dir=1, busy=0, done=0, err=0; all latched config cleared. Reset wins over every other input, including mid-run; no done is generated.
- States: IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE (encoded per package).
- IDLE, start=1:
  - If lo<hi and n_sweeps≠0: latch lo/hi/n_sweeps/dwell, count<=lo, dir<=1, go to UP.
  - Otherwise: err=1 for one cycle, stay IDLE, count unchanged.
  - start=0: count and dir hold.
- UP:
  - If count≠hi_q: count<=count+1.
  - Else: count holds, dir<=0, go to DWELL_HI if dwell_q≠0, else DOWN.
- DWELL_HI: count holds for exactly dwell_q cycles, then go to DOWN.
- DOWN:
  - If count≠lo_q: count<=count−1.
  - Else, last sweep (remaining=1): go to DONE.
  - Else: decrement remaining, dir<=1, go to DWELL_LO if dwell_q≠0, else UP.
- DWELL_LO: count holds for exactly dwell_q cycles, then go to UP.
- DONE: done=1, busy=0, count holds lo_q. Next cycle goes to IDLE.
- Cycle counts: each bound value appears 2+dwell consecutive cycles at an interior turnaround. One sweep with dwell 0 is busy for 2·(hi−lo+1) cycles.
- abort=1 in any busy state: next cycle IDLE, busy=0, count and dir hold their current values, no done. abort in IDLE or DONE is ignored. abort beats a same-cycle turnaround.
- start while busy or in DONE is ignored, and config inputs are not re-sampled.
- Arithmetic: count always stays within [lo_q, hi_q], so it never wraps. hi=2^WIDTH−1 and lo=0 are legal. The remaining-sweep counter is SWEEP_W bits and never underflows, because zero is rejected at start.

Decomposition:
- Package sweep_ctrl_pkg holds the state encoding localparams (ST_IDLE … ST_DONE, 3-bit) and the default width constants.
- One sub-module, updown_cnt_ld: WIDTH-bit counter with en, load, load_val, updown, and the same synchronous active-low rst. It has no internal wrap logic; sweep_ctrl guarantees the bounds.
- sweep_ctrl contains the FSM, config registers, dwell counter, and sweep counter.

Test Plan:
1. Reset: rst=0 for 2 cycles mid-activity → count=0, dir=1, busy=done=err=0, state IDLE.
2. Basic run: lo=2, hi=5, n=1, dwell=0, start pulse → count over 8 busy cycles = 2,3,4,5,5,4,3,2, with dir going 0 on the second 5. Then one done cycle with count=2, then IDLE.
3. Full range with dwell: lo=0, hi=15, n=2, dwell=3 → no wrap. 15 is held 5 consecutive cycles per sweep and 0 is held 5 cycles between sweeps. Total busy = 73 cycles, then a single done pulse.
4. Rejected starts: lo=5, hi=5 (and separately lo=3, hi=9, n=0) → err pulses 1 cycle, busy stays 0, count unchanged.
5. Abort: lo=1, hi=8, n=1, dwell=0; assert abort when count=6 in DOWN → next cycle busy=0, count=6, dir=0, no done. A start pulsed during the run before the abort is ignored.
6. Reset mid-run: rst=0 while count=4 in UP → count=0, busy=0, no done. A subsequent valid start runs normally.

Source files
------------

// File: rtl/sweep_ctrl_pkg.sv
// Shared state encoding and default widths for the triangle-sweep sequencer.
package sweep_ctrl_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int SWEEP_W_DEF = 4;
    localparam int DWELL_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UP       = 3'd1,
        ST_DWELL_HI = 3'd2,
        ST_DOWN     = 3'd3,
        ST_DWELL_LO = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/sweep_ctrl_updown_cnt_ld.sv
// Loadable up/down counter; the caller keeps the value within its bounds.
module updown_cnt_ld
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             updown,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= updown ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Sequences lo->hi->lo triangle sweeps on an up/down counter, with optional
// dwell at each turnaround and host-facing busy/done/err status.
module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SWEEP_W = SWEEP_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] n_sweeps,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             state;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [SWEEP_W-1:0] rem_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dcnt;

    logic start_ok;
    logic in_busy;
    logic cnt_en;
    logic cnt_load;
    logic cnt_up;

    assign start_ok = (lo < hi) && (n_sweeps != '0);
    assign in_busy  = (state == ST_UP) || (state == ST_DWELL_HI) ||
                      (state == ST_DOWN) || (state == ST_DWELL_LO);

    // Counter steps only while strictly inside the bounds; abort freezes it.
    always_comb begin
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_up   = 1'b1;
        case (state)
            ST_IDLE: cnt_load = start && start_ok;
            ST_UP:   cnt_en   = !abort && (count != hi_q);
            ST_DOWN: begin
                cnt_up = 1'b0;
                cnt_en = !abort && (count != lo_q);
            end
            default: ;
        endcase
    end

    updown_cnt_ld #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en),
        .load     (cnt_load),
        .load_val (lo),
        .updown   (cnt_up),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            rem_q   <= '0;
            dwell_q <= '0;
            dcnt    <= '0;
            dir     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && in_busy) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (start_ok) begin
                                lo_q    <= lo;
                                hi_q    <= hi;
                                rem_q   <= n_sweeps;
                                dwell_q <= dwell;
                                dir     <= 1'b1;
                                busy    <= 1'b1;
                                state   <= ST_UP;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_UP: begin
                        if (count == hi_q) begin
                            dir <= 1'b0;
                            if (dwell_q != '0) begin
                                dcnt  <= dwell_q - DWELL_W'(1);
                                state <= ST_DWELL_HI;
                            end else begin
                                state <= ST_DOWN;
                            end
                        end
                    end
                    ST_DWELL_HI: begin
                        if (dcnt == '0) state <= ST_DOWN;
                        else            dcnt  <= dcnt - DWELL_W'(1);
                    end
                    ST_DOWN: begin
                        if (count == lo_q) begin
                            if (rem_q == SWEEP_W'(1)) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                rem_q <= rem_q - SWEEP_W'(1);
                                dir   <= 1'b1;
                                if (dwell_q != '0) begin
                                    dcnt  <= dwell_q - DWELL_W'(1);
                                    state <= ST_DWELL_LO;
                                end else begin
                                    state <= ST_UP;
                                end
                            end
                        end
                    end
                    ST_DWELL_LO: begin
                        if (dcnt == '0) state <= ST_UP;
                        else            dcnt  <= dcnt - DWELL_W'(1);
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
